// File: rtl/cl_head_gen.sv
// cl_head_gen: transmit-side cache-line framer.
// Packs ST words MSB-first into a 512-bit cache line and prepends a 16-bit
// header {3'b000, last, count[11:0]}. It also reports the frame length in STs
// as a sideband.
// Optional build macro: CL_HEAD_GEN_PAD_ZERO_EN. When defined, the payload
// slots are cleared after each line leaves, so unused slots of a short line
// read as zero.
module cl_head_gen #(
  parameter int CL                  = 512,
  parameter int CL_HEAD             = 16,
  parameter int CL_PAYLOAD          = CL - CL_HEAD,
  parameter int ST_W                = 16,
  parameter int w_NumOfST_in_AFUFrm = 16
) (
  input  logic                           clk,
  input  logic                           rst_n_sync,
  input  logic [ST_W-1:0]                st_data,
  input  logic                           st_valid,
  input  logic                           st_last,
  output logic                           st_ready,
  output logic [CL-1:0]                  source_data,
  output logic                           source_valid,
  input  logic                           source_ready,
  output logic [w_NumOfST_in_AFUFrm-1:0] sb_len,
  output logic                           sb_len_vld
);

  localparam int N_ST   = CL_PAYLOAD / ST_W;
  localparam int CNT_W  = $clog2(N_ST + 1);
  localparam int HCNT_W = CL_HEAD - 4;
  localparam int LEN_W  = w_NumOfST_in_AFUFrm;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_OUT  = 2'd1
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CL-1:0]           data_q;
  logic                    st_ready_q;
  logic                    source_valid_q;
  logic [LEN_W-1:0]        acc_q;
  logic [LEN_W-1:0]        sb_len_q;
  logic                    sb_len_vld_q;

  logic [CL_PAYLOAD-1:0]   payload_d;
  logic [HCNT_W-1:0]       hdr_cnt_d;
  logic [HCNT_W-1:0]       out_cnt;
  logic                    out_last;
  logic [LEN_W-1:0]        acc_sum;
  logic                    st_acc;
  logic                    cl_acc;

  // Handshakes. st_ready_q is only ever set while filling, so st_acc implies S_FILL.
  assign st_acc = st_valid & st_ready_q;
  assign cl_acc = source_valid_q & source_ready;

  // Count field for the line being closed: slots already written plus this ST.
  assign hdr_cnt_d = HCNT_W'(cnt_q) + HCNT_W'(1);

  // Header fields of the held line feed the frame-length accumulator.
  assign out_cnt  = data_q[CL-5 -: HCNT_W];
  assign out_last = data_q[CL-4];
  assign acc_sum  = acc_q + LEN_W'(out_cnt);

  // Next payload: only the slot addressed by cnt_q takes the incoming ST.
  // Slot 0 sits directly below the header.
  genvar gi;
  generate
    for (gi = 0; gi < N_ST; gi++) begin : g_slot
      assign payload_d[CL_PAYLOAD-1-gi*ST_W -: ST_W] =
        (cnt_q == CNT_W'(gi)) ? st_data : data_q[CL_PAYLOAD-1-gi*ST_W -: ST_W];
    end
  endgenerate

  // Framing FSM with registered handshake outputs, line buffer and length accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      state_q        <= S_FILL;
      cnt_q          <= '0;
      data_q         <= '0;
      st_ready_q     <= 1'b0;
      source_valid_q <= 1'b0;
      acc_q          <= '0;
      sb_len_q       <= '0;
      sb_len_vld_q   <= 1'b0;
    end else begin
      sb_len_vld_q <= 1'b0;
      case (state_q)
        S_FILL: begin
          st_ready_q     <= 1'b1;
          source_valid_q <= 1'b0;
          if (st_acc) begin
            data_q[CL_PAYLOAD-1:0] <= payload_d;
            cnt_q                  <= cnt_q + CNT_W'(1);
            // Close the line on end of frame or when the last slot is filled.
            // A 31st ST carrying st_last closes a single full line with last = 1.
            if (st_last || (cnt_q == CNT_W'(N_ST - 1))) begin
              data_q[CL-1 -: CL_HEAD] <= {3'b000, st_last, hdr_cnt_d};
              state_q                 <= S_OUT;
              st_ready_q              <= 1'b0;
              source_valid_q          <= 1'b1;
            end
          end
        end
        S_OUT: begin
          st_ready_q     <= 1'b0;
          source_valid_q <= 1'b1;
          if (cl_acc) begin
            cnt_q          <= '0;
            state_q        <= S_FILL;
            st_ready_q     <= 1'b1;
            source_valid_q <= 1'b0;
            if (out_last) begin
              sb_len_q     <= acc_sum;
              sb_len_vld_q <= 1'b1;
              acc_q        <= '0;
            end else begin
              acc_q <= acc_sum;
            end
`ifdef CL_HEAD_GEN_PAD_ZERO_EN
            data_q[CL_PAYLOAD-1:0] <= '0;
`else
            data_q[CL_PAYLOAD-1:0] <= data_q[CL_PAYLOAD-1:0];
`endif
          end
        end
        default: begin
          state_q        <= S_FILL;
          cnt_q          <= '0;
          data_q         <= '0;
          st_ready_q     <= 1'b0;
          source_valid_q <= 1'b0;
          acc_q          <= '0;
          sb_len_q       <= '0;
          sb_len_vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign st_ready     = st_ready_q;
  assign source_valid = source_valid_q;
  assign source_data  = data_q;
  assign sb_len       = sb_len_q;
  assign sb_len_vld   = sb_len_vld_q;

endmodule

// File: tb/tb_cl_head_gen.sv
// Directed testbench for cl_head_gen. Inputs are driven and outputs sampled
// on the falling clock edge; the DUT registers on the rising edge.
module tb_cl_head_gen;

  logic         clk = 1'b0;
  logic         rst_n_sync;
  logic [15:0]  st_data;
  logic         st_valid;
  logic         st_last;
  logic         st_ready;
  logic [511:0] source_data;
  logic         source_valid;
  logic         source_ready;
  logic [15:0]  sb_len;
  logic         sb_len_vld;

  int vectors     = 0;
  int miscompares = 0;
  int cl_seen     = 0;

  always #5 clk = ~clk;

  cl_head_gen dut (
    .clk          (clk),
    .rst_n_sync   (rst_n_sync),
    .st_data      (st_data),
    .st_valid     (st_valid),
    .st_last      (st_last),
    .st_ready     (st_ready),
    .source_data  (source_data),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .sb_len       (sb_len),
    .sb_len_vld   (sb_len_vld)
  );

  // Payload slot k (0 = directly below the header).
  function automatic logic [15:0] slot(input logic [511:0] d, input int k);
    return 16'(d >> ((30 - k) * 16));
  endfunction

  // Present one ST at a falling edge and wait until it is accepted.
  task automatic send_st(input logic [15:0] d, input logic l);
    int guard = 0;
    while (st_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL send_st_timeout st_ready=%b required 1", st_ready);
    end
    st_valid = 1'b1;
    st_data  = d;
    st_last  = l;
    @(negedge clk);
    st_valid = 1'b0;
    st_last  = 1'b0;
    st_data  = 16'h0000;
  endtask

  // Wait for a held line, capture it and complete one handshake.
  task automatic collect_cl(output logic [511:0] d);
    int guard = 0;
    while (source_valid !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL collect_timeout source_valid=%b required 1", source_valid);
    end
    d = source_data;
    source_ready = 1'b1;
    @(negedge clk);
    source_ready = 1'b0;
    cl_seen++;
    $display("cl %0d header=%h slot0=%h", cl_seen, d[511:496], slot(d, 0));
  endtask

  task automatic test_reset();
    rst_n_sync   = 1'b0;
    st_valid     = 1'b0;
    st_last      = 1'b0;
    st_data      = 16'h0000;
    source_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (st_ready !== 1'b0) begin miscompares++; $display("FAIL rst_st_ready got %b exp 0", st_ready); end
    vectors++; if (source_valid !== 1'b0) begin miscompares++; $display("FAIL rst_source_valid got %b exp 0", source_valid); end
    vectors++; if (source_data !== 512'd0) begin miscompares++; $display("FAIL rst_source_data hdr got %h exp 0", source_data[511:496]); end
    vectors++; if (sb_len !== 16'd0) begin miscompares++; $display("FAIL rst_sb_len got %h exp 0", sb_len); end
    vectors++; if (sb_len_vld !== 1'b0) begin miscompares++; $display("FAIL rst_sb_len_vld got %b exp 0", sb_len_vld); end
    rst_n_sync = 1'b1;
    @(negedge clk);
    vectors++; if (st_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_st_ready got %b exp 1", st_ready); end
    vectors++; if (source_valid !== 1'b0) begin miscompares++; $display("FAIL post_rst_source_valid got %b exp 0", source_valid); end
    $display("reset done");
  endtask

  task automatic test_single_st();
    logic [511:0] d;
    send_st(16'hA5A5, 1'b1);
    vectors++; if (source_valid !== 1'b1) begin miscompares++; $display("FAIL single_latency source_valid got %b exp 1", source_valid); end
    vectors++; if (st_ready !== 1'b0) begin miscompares++; $display("FAIL single_st_ready got %b exp 0", st_ready); end
    collect_cl(d);
    vectors++; if (d[511:496] !== 16'h1001) begin miscompares++; $display("FAIL single_header got %h exp 1001", d[511:496]); end
    vectors++; if (d[495:480] !== 16'hA5A5) begin miscompares++; $display("FAIL single_slot0 got %h exp a5a5", d[495:480]); end
    vectors++; if (sb_len_vld !== 1'b1) begin miscompares++; $display("FAIL single_sb_len_vld got %b exp 1", sb_len_vld); end
    vectors++; if (sb_len !== 16'd1) begin miscompares++; $display("FAIL single_sb_len got %0d exp 1", sb_len); end
    @(negedge clk);
    vectors++; if (sb_len_vld !== 1'b0) begin miscompares++; $display("FAIL single_vld_pulse got %b exp 0", sb_len_vld); end
    vectors++; if (source_valid !== 1'b0) begin miscompares++; $display("FAIL single_one_cl got %b exp 0", source_valid); end
  endtask

  task automatic test_full_cl();
    logic [511:0] d;
    for (int i = 1; i <= 31; i++) begin
      send_st(16'(i), (i == 31));
      if (i == 30) begin
        vectors++; if (source_valid !== 1'b0) begin miscompares++; $display("FAIL full_early_close got %b exp 0", source_valid); end
      end
    end
    collect_cl(d);
    vectors++; if (d[511:496] !== 16'h101F) begin miscompares++; $display("FAIL full_header got %h exp 101f", d[511:496]); end
    vectors++; if (d[495:480] !== 16'd1) begin miscompares++; $display("FAIL full_slot0 got %h exp 0001", d[495:480]); end
    vectors++; if (d[15:0] !== 16'd31) begin miscompares++; $display("FAIL full_slot30 got %h exp 001f", d[15:0]); end
    vectors++; if (sb_len !== 16'd31 || sb_len_vld !== 1'b1) begin miscompares++; $display("FAIL full_sb_len got %0d/%b exp 31/1", sb_len, sb_len_vld); end
    @(negedge clk);
    vectors++; if (source_valid !== 1'b0) begin miscompares++; $display("FAIL full_no_empty_cl got %b exp 0", source_valid); end
  endtask

  task automatic test_multi_cl();
    logic [511:0] d;
    logic [15:0]  exp_hdr;
    for (int i = 0; i < 70; i++) begin
      send_st(16'h0100 + 16'(i), (i == 69));
      if (((i + 1) % 31 == 0) || (i == 69)) begin
        @(negedge clk);
        vectors++; if (st_ready !== 1'b0) begin miscompares++; $display("FAIL multi_st_ready_out got %b exp 0", st_ready); end
        collect_cl(d);
        exp_hdr = (i == 69) ? 16'h1008 : 16'h001F;
        vectors++; if (d[511:496] !== exp_hdr) begin miscompares++; $display("FAIL multi_header got %h exp %h", d[511:496], exp_hdr); end
        vectors++; if (slot(d, 0) !== 16'h0100 + 16'((i / 31) * 31)) begin miscompares++; $display("FAIL multi_slot0 got %h exp %h", slot(d, 0), 16'h0100 + 16'((i / 31) * 31)); end
        vectors++; if (sb_len_vld !== (i == 69)) begin miscompares++; $display("FAIL multi_vld got %b exp %b", sb_len_vld, (i == 69)); end
      end
    end
    vectors++; if (sb_len !== 16'd70) begin miscompares++; $display("FAIL multi_sb_len got %0d exp 70", sb_len); end
  endtask

  task automatic test_back_pressure();
    logic [511:0] snap;
    logic [511:0] d;
    for (int i = 0; i < 5; i++) send_st(16'hB000 + 16'(i), (i == 4));
    snap = source_data;
    vectors++; if (snap[511:496] !== 16'h1005) begin miscompares++; $display("FAIL bp_header got %h exp 1005", snap[511:496]); end
    vectors++; if (slot(snap, 4) !== 16'hB004) begin miscompares++; $display("FAIL bp_slot4 got %h exp b004", slot(snap, 4)); end
    // Junk STs offered while the line is held must be ignored.
    st_valid = 1'b1;
    st_data  = 16'hFFFF;
    st_last  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (source_data !== snap || source_valid !== 1'b1 || st_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold cyc=%0d got hdr=%h vld=%b rdy=%b exp hdr=%h vld=1 rdy=0", c, source_data[511:496], source_valid, st_ready, snap[511:496]);
      end
    end
    st_valid = 1'b0;
    st_last  = 1'b0;
    collect_cl(d);
    source_ready = 1'b1;
    vectors++; if (source_valid !== 1'b0) begin miscompares++; $display("FAIL bp_one_handshake got %b exp 0", source_valid); end
    vectors++; if (sb_len !== 16'd5 || sb_len_vld !== 1'b1) begin miscompares++; $display("FAIL bp_sb_len got %0d/%b exp 5/1", sb_len, sb_len_vld); end
    @(negedge clk);
    vectors++; if (sb_len_vld !== 1'b0 || source_valid !== 1'b0) begin miscompares++; $display("FAIL bp_extra got vld=%b sv=%b exp 0/0", sb_len_vld, source_valid); end
    source_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [511:0] d;
    for (int i = 0; i < 12; i++) send_st(16'hE000 + 16'(i), 1'b0);
    vectors++; if (source_valid !== 1'b0) begin miscompares++; $display("FAIL mid_premature got %b exp 0", source_valid); end
    rst_n_sync = 1'b0;
    @(negedge clk);
    vectors++; if (st_ready !== 1'b0 || source_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_hs got rdy=%b sv=%b exp 0/0", st_ready, source_valid); end
    vectors++; if (source_data !== 512'd0) begin miscompares++; $display("FAIL mid_rst_data slot0 got %h exp 0", slot(source_data, 0)); end
    vectors++; if (sb_len !== 16'd0 || sb_len_vld !== 1'b0) begin miscompares++; $display("FAIL mid_rst_sb got %0d/%b exp 0/0", sb_len, sb_len_vld); end
    rst_n_sync = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++; if (source_valid !== 1'b0) begin miscompares++; $display("FAIL mid_no_cl got %b exp 0", source_valid); end
    end
    send_st(16'hF001, 1'b0);
    send_st(16'hF002, 1'b0);
    send_st(16'hF003, 1'b1);
    collect_cl(d);
    vectors++; if (d[511:496] !== 16'h1003) begin miscompares++; $display("FAIL mid_header got %h exp 1003", d[511:496]); end
    vectors++; if (slot(d, 2) !== 16'hF003 || slot(d, 3) !== 16'h0000) begin miscompares++; $display("FAIL mid_slots got %h/%h exp f003/0000", slot(d, 2), slot(d, 3)); end
    vectors++; if (sb_len !== 16'd3 || sb_len_vld !== 1'b1) begin miscompares++; $display("FAIL mid_sb_len got %0d/%b exp 3/1", sb_len, sb_len_vld); end
  endtask

  task automatic test_padding();
    logic [511:0] d;
    logic [15:0]  exp_slot;
    for (int i = 1; i <= 31; i++) send_st(16'hC000 + 16'(i), (i == 31));
    collect_cl(d);
    send_st(16'hD001, 1'b0);
    send_st(16'hD002, 1'b1);
    collect_cl(d);
    vectors++; if (d[511:496] !== 16'h1002) begin miscompares++; $display("FAIL pad_header got %h exp 1002", d[511:496]); end
    vectors++; if (slot(d, 0) !== 16'hD001 || slot(d, 1) !== 16'hD002) begin miscompares++; $display("FAIL pad_data got %h/%h exp d001/d002", slot(d, 0), slot(d, 1)); end
    for (int k = 2; k <= 30; k++) begin
`ifdef CL_HEAD_GEN_PAD_ZERO_EN
      exp_slot = 16'h0000;
`else
      exp_slot = 16'hC000 + 16'(k + 1);
`endif
      vectors++; if (slot(d, k) !== exp_slot) begin miscompares++; $display("FAIL pad_slot%0d got %h exp %h", k, slot(d, k), exp_slot); end
    end
    vectors++; if (sb_len !== 16'd2) begin miscompares++; $display("FAIL pad_sb_len got %0d exp 2", sb_len); end
  endtask

  initial begin
    test_reset();
    test_single_st();
    test_full_cl();
    test_multi_cl();
    test_back_pressure();
    test_reset_mid();
    test_padding();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cl_head_gen.md
# cl_head_gen

Transmit-side cache-line framer for the AFU data path. Accepts a stream of fixed-width ST words, packs them MSB-first into 512-bit cache lines, and prepends a 16-bit header carrying the ST count and the end-of-AFU-frame flag. Its output feeds the cache-line FIFO whose receiving end parses the same header. It also reports the total frame length in STs as a sideband.

## Interface
Parameters:
- CL, 512, cache-line width in bits
- CL_HEAD, 16, header width in bits
- CL_PAYLOAD, 496, payload width in bits (CL - CL_HEAD)
- ST_W, 16, ST word width; STs per CL is N_ST = CL_PAYLOAD/ST_W = 31
- w_NumOfST_in_AFUFrm, 16, width of the frame-length sideband

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n_sync  in  1  reset, synchronous, active-low
- st_data  in  ST_W  ST word
- st_valid  in  1  st_data valid
- st_last  in  1  qualifies st_data as the last ST of the AFU frame
- st_ready  out  1  block accepts an ST this cycle
- source_data  out  CL  header plus payload
- source_valid  out  1  source_data valid
- source_ready  in  1  downstream accepts the cache line
- sb_len  out  w_NumOfST_in_AFUFrm  ST count of the last completed frame
- sb_len_vld  out  1  one-cycle pulse when sb_len updates

## Operation
- Header layout: [CL-1:CL-3] = 0; [CL-4] = last (end of AFU frame); [CL-5:CL-16] = ST count in this CL (12 bits, range 1..31).
- Payload layout: ST k of the CL (k = 0..30) occupies [CL_PAYLOAD-1-k*ST_W -: ST_W]. ST 0 sits directly below the header.
- An ST is accepted when st_valid & st_ready.
- FSM, 2-bit state:
  - S_FILL (reset state): st_ready = 1, source_valid = 0. Each accepted ST is written to slot cnt, and cnt increments.
    - ST accepted with st_last = 1 → S_OUT, header last = 1.
    - ST accepted with cnt == 30 and st_last = 0 → S_OUT, header last = 0.
  - S_OUT: st_ready = 0, source_valid = 1. source_data is held stable. On source_ready: cnt ← 0, go to S_FILL.
  - Any other encoding → S_FILL, with all outputs at their reset values.
- st_ready and source_valid are decoded from registered state only. There is no combinational path from source_ready to st_ready.
- The 31st ST arriving with st_last = 1 produces one CL: count = 31, last = 1. No empty trailing CL is generated.
- A frame always contains at least one ST, because st_last is only meaningful with st_valid.
- Frame-length accumulator:
  - For each CL accepted downstream, the accumulator adds the CL's ST count. Addition wraps modulo 2^w_NumOfST_in_AFUFrm.
  - When the accepted CL has last = 1: sb_len ← accumulator + count, sb_len_vld pulses, accumulator ← 0.
- Reset mid-operation discards any partial CL and any held CL; no header is emitted for them.

## Timing
- Reset values: st_ready 0, source_valid 0, source_data 0, sb_len 0, sb_len_vld 0, state S_FILL, cnt 0, accumulator 0.
- First cycle after reset deasserts: st_ready = 1.
- Latency: source_valid asserts on the cycle after the closing ST is accepted.
- Throughput: N STs cost N accept cycles plus at least 1 output cycle per CL. A full CL costs at least 32 cycles.
- sb_len and sb_len_vld update on the cycle after the last-flagged CL handshake.
- Back-pressure: source_data and source_valid are held unchanged while source_ready = 0.
- st_data and st_last are ignored while st_ready = 0.

## Configuration
- CL_HEAD_GEN_PAD_ZERO_EN
  - Defined: on each S_OUT→S_FILL transition, payload slots are cleared to 0. Unused slots of a short CL read as 0.
  - Undefined: slots are not cleared. Unused slots of a short CL hold stale STs from the previous CL (0 after reset).
  - Header and sb_len behaviour are identical in both builds.

## Test plan
- Single-ST frame: st_data = 16'hA5A5, st_last = 1, source_ready = 1.
  - Expect one CL: [511:496] = 16'h1001, [495:480] = 16'hA5A5.
  - Expect sb_len = 1 with one sb_len_vld pulse.
- Full CL: 31 STs with values 1..31, st_last on ST 31.
  - Expect header 16'h101F, ST 1 at [495:480], ST 31 at [15:0].
  - Expect sb_len = 31.
- Multi-CL frame of 70 STs.
  - Expect headers 16'h001F, 16'h001F, 16'h1008.
  - Expect sb_len = 70; st_ready = 0 in each S_OUT cycle.
- Back-pressure: hold source_ready = 0 for 10 cycles during S_OUT.
  - Expect source_data constant, st_ready = 0, no ST lost.
  - Then source_ready = 1 → exactly one handshake.
- Reset mid-frame: 12 STs accepted, then rst_n_sync = 0 for 1 cycle.
  - Expect all outputs at reset values and no CL emitted.
  - A following 3-ST frame yields header 16'h1003 and sb_len = 3.
- Padding: a 31-ST frame, then a 2-ST frame.
  - With CL_HEAD_GEN_PAD_ZERO_EN: slots 2..30 of the second CL are 0.
  - Without it: slots 2..30 equal STs 3..31 of the first frame.
